// File: rtl/scan_pkg.sv
// Shared definitions for the scan decoder: mode encodings and a helper that
// identifies the two auto-advancing scan modes.
package scan_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT    = 2'b00,
      MODE_SCAN_UP   = 2'b01,
      MODE_SCAN_DOWN = 2'b10,
      MODE_OFF       = 2'b11
   } scan_mode_t;

   function automatic logic is_scan(input logic [1:0] m);
      return (m == MODE_SCAN_UP) || (m == MODE_SCAN_DOWN);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-period prescaler: counts while run is high and reports a step when the
// count matches period. A match wraps the counter, so a step occurs every period+1 cycles.
module scan_prescaler #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             clear,
   input  logic [DIV_W-1:0] period,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic             hit;

   // An equality compare means a count above a freshly lowered period wraps
   // through the counter's full range before matching, so no step is skipped.
   assign hit  = (cnt == period);
   assign tick = run && !clear && hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= hit ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with an auto-advancing scan index,
// used for display-digit multiplexing and keypad row strobing.
module scan_decoder
   import scan_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DIV_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      s,
   input  logic                  load,
   input  logic [DIV_W-1:0]      period,
   output logic [(2**SEL_W)-1:0] d,
   output logic [SEL_W-1:0]      idx,
   output logic                  tick
);

   localparam int OUT_W = 2**SEL_W;

   logic [1:0]       mode_prev;
   logic             mode_chg;
   logic             run;
   logic             clear;
   logic             step;
   logic             out_en;
   logic [SEL_W-1:0] idx_next;
   logic [OUT_W-1:0] d_next;

   // Any mode change restarts the period count; DIRECT pins it at zero.
   assign mode_chg = (mode != mode_prev);
   assign run      = en && is_scan(mode);
   assign clear    = load || mode_chg || (mode == MODE_DIRECT);
   assign out_en   = en && (mode != MODE_OFF);

   scan_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .clear  (clear),
      .period (period),
      .tick   (step)
   );

   always_comb begin
      idx_next = idx;
      if (load) begin
         idx_next = s;
      end else if (en && (mode == MODE_DIRECT)) begin
         idx_next = s;
      end else if (step) begin
         idx_next = (mode == MODE_SCAN_UP) ? idx + SEL_W'(1) : idx - SEL_W'(1);
      end
   end

   // Decoding from the single index guarantees one-hot or all-zero output.
   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_onehot
      assign d_next[gi] = out_en && (idx_next == SEL_W'(gi));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d         <= '0;
         idx       <= '0;
         tick      <= 1'b0;
         mode_prev <= MODE_DIRECT;
      end else begin
         d         <= d_next;
         idx       <= idx_next;
         tick      <= step;
         mode_prev <= mode;
      end
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed vector table, async reset,
// randomized run against a reference model, and a 4-bit select instance.
module tb_scan_decoder;
   import scan_pkg::*;

   localparam logic [1:0] M_D  = 2'b00;
   localparam logic [1:0] M_U  = 2'b01;
   localparam logic [1:0] M_DN = 2'b10;
   localparam logic [1:0] M_O  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, load;
   logic [1:0]  mode;
   logic [2:0]  s;
   logic [15:0] period;
   logic [7:0]  d;
   logic [2:0]  idx;
   logic        tick;

   logic        en4, load4;
   logic [1:0]  mode4;
   logic [3:0]  s4;
   logic [3:0]  period4;
   logic [15:0] d4;
   logic [3:0]  idx4;
   logic        tick4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(3), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .load(load),
      .period(period), .d(d), .idx(idx), .tick(tick)
   );

   scan_decoder #(.SEL_W(4), .DIV_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .mode(mode4), .s(s4), .load(load4),
      .period(period4), .d(d4), .idx(idx4), .tick(tick4)
   );

   typedef struct {
      logic        en;
      logic [1:0]  mode;
      logic [2:0]  s;
      logic        load;
      logic [15:0] period;
      logic [2:0]  e_idx;
      logic [7:0]  e_d;
      logic        e_tick;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: index, cycles counted in the current period, last mode.
   int       m_idx, m_cnt, m_mode;
   bit       m_tick;
   logic [7:0] m_d;

   function automatic void add(input logic e, input logic [1:0] m, input logic [2:0] sv,
                               input logic l, input logic [15:0] p, input logic [2:0] ei,
                               input logic [7:0] ed, input logic et, input int n);
      vec_t v;
      v.en = e; v.mode = m; v.s = sv; v.load = l; v.period = p;
      v.e_idx = ei; v.e_d = ed; v.e_tick = et;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check3(input string name, input logic [2:0] ei, input logic [7:0] ed,
                         input logic et);
      checks++;
      if (idx !== ei || d !== ed || tick !== et) begin
         errors++;
         $display("FAIL %s: got idx=%0d d=%b tick=%b, expected idx=%0d d=%b tick=%b",
                  name, idx, d, tick, ei, ed, et);
      end else begin
         $display("ok   %s: idx=%0d d=%b tick=%b", name, idx, d, tick);
      end
   endtask

   task automatic check4(input string name, input logic [3:0] ei, input logic [15:0] ed,
                         input logic et);
      checks++;
      if (idx4 !== ei || d4 !== ed || tick4 !== et) begin
         errors++;
         $display("FAIL %s: got idx=%0d d=%b tick=%b, expected idx=%0d d=%b tick=%b",
                  name, idx4, d4, tick4, ei, ed, et);
      end else begin
         $display("ok   %s: idx=%0d d=%b tick=%b", name, idx4, d4, tick4);
      end
   endtask

   // Advance the model by one clock edge using the currently applied inputs.
   task automatic model_step();
      bit stp;
      bit scan;
      stp  = 0;
      scan = (mode == M_U) || (mode == M_DN);
      if (load || int'(mode) != m_mode || mode == M_D) begin
         m_cnt = 0;
      end else if (en && scan) begin
         if (m_cnt == int'(period)) begin
            m_cnt = 0;
            stp   = 1;
         end else begin
            m_cnt = (m_cnt + 1) % 65536;
         end
      end
      if (load || (en && mode == M_D)) m_idx = int'(s);
      else if (stp) m_idx = (mode == M_U) ? (m_idx + 1) % 8 : (m_idx + 7) % 8;
      m_tick = stp;
      m_d    = (en && mode != M_O) ? 8'(1 << m_idx) : 8'h00;
      m_mode = int'(mode);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = M_D; s = '0; load = 1'b0; period = '0;
      en4 = 1'b0; mode4 = M_D; s4 = '0; load4 = 1'b0; period4 = '0;

      // Directed table: DIRECT, scan up/down with wrap, en freeze, load-on-step,
      // mode change mid-count, OFF, load while disabled.
      add(1, M_D, 5, 0, 0, 5, 8'h20, 0, 1);
      add(1, M_D, 2, 0, 0, 2, 8'h04, 0, 1);
      add(1, M_U, 6, 1, 3, 6, 8'h40, 0, 1);
      add(1, M_U, 0, 0, 3, 6, 8'h40, 0, 3);
      add(1, M_U, 0, 0, 3, 7, 8'h80, 1, 1);
      add(1, M_U, 0, 0, 3, 7, 8'h80, 0, 3);
      add(1, M_U, 0, 0, 3, 0, 8'h01, 1, 1);
      add(1, M_U, 0, 0, 3, 0, 8'h01, 0, 3);
      add(1, M_U, 0, 0, 3, 1, 8'h02, 1, 1);
      add(1, M_DN, 1, 1, 0, 1, 8'h02, 0, 1);
      add(1, M_DN, 0, 0, 0, 0, 8'h01, 1, 1);
      add(1, M_DN, 0, 0, 0, 7, 8'h80, 1, 1);
      add(1, M_DN, 0, 0, 0, 6, 8'h40, 1, 1);
      add(1, M_U, 3, 1, 2, 3, 8'h08, 0, 1);
      add(1, M_U, 0, 0, 2, 3, 8'h08, 0, 1);
      add(0, M_U, 0, 0, 2, 3, 8'h00, 0, 5);
      add(1, M_U, 0, 0, 2, 3, 8'h08, 0, 1);
      add(1, M_U, 0, 0, 2, 4, 8'h10, 1, 1);
      add(1, M_U, 0, 0, 2, 4, 8'h10, 0, 2);
      add(1, M_U, 2, 1, 2, 2, 8'h04, 0, 1);
      add(1, M_U, 0, 0, 2, 2, 8'h04, 0, 2);
      add(1, M_U, 0, 0, 2, 3, 8'h08, 1, 1);
      add(1, M_U, 0, 0, 2, 3, 8'h08, 0, 1);
      add(1, M_DN, 0, 0, 2, 3, 8'h08, 0, 3);
      add(1, M_DN, 0, 0, 2, 2, 8'h04, 1, 1);
      add(1, M_O, 0, 0, 2, 2, 8'h00, 0, 2);
      add(0, M_O, 5, 1, 2, 5, 8'h00, 0, 1);

      repeat (3) @(posedge clk);
      #1;
      check3("reset", 3'd0, 8'h00, 1'b0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         en = vecs[i].en; mode = vecs[i].mode; s = vecs[i].s;
         load = vecs[i].load; period = vecs[i].period;
         cyc();
         check3($sformatf("vec%0d", i), vecs[i].e_idx, vecs[i].e_d, vecs[i].e_tick);
      end

      // Asynchronous reset between edges during a scan.
      en = 1'b1; mode = M_U; period = 16'd0; s = 3'd4; load = 1'b1;
      cyc();
      load = 1'b0;
      cyc();
      check3("pre_async", 3'd5, 8'h20, 1'b1);
      #3 rst = 1'b1;
      #1;
      check3("async_rst", 3'd0, 8'h00, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      mode = M_D; en = 1'b1; s = 3'd0; load = 1'b0;
      m_idx = 0; m_cnt = 0; m_mode = 0;

      // Randomized run against the reference model.
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
         load = ($urandom_range(0, 15) == 0);
         s = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) period = 16'($urandom_range(0, 4));
         model_step();
         cyc();
         check3($sformatf("rand%0d", i), 3'(m_idx), m_d, m_tick);
      end

      // 4-bit select: full DIRECT sweep.
      en4 = 1'b1; mode4 = M_D;
      for (int v = 0; v < 16; v++) begin
         s4 = 4'(v);
         cyc();
         check4($sformatf("sweep%0d", v), 4'(v), 16'(1) << v, 1'b0);
      end

      // Period lowered below the running count: count wraps through 15, then matches.
      mode4 = M_U; s4 = 4'd0; load4 = 1'b1; period4 = 4'd10;
      cyc();
      check4("p_load", 4'd0, 16'h0001, 1'b0);
      load4 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         check4($sformatf("p_run%0d", k), 4'd0, 16'h0001, 1'b0);
      end
      period4 = 4'd3;
      for (int k = 0; k < 11; k++) begin
         cyc();
         check4($sformatf("p_wrap%0d", k), 4'd0, 16'h0001, 1'b0);
      end
      cyc();
      check4("p_step", 4'd1, 16'h0002, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered binary-to-one-hot decoder. Generalises the fixed 3-to-8 combinational decoder to SEL_W-to-2^SEL_W.
- Adds a sequential scan engine: an internal index auto-advances up or down at a programmable rate, for display-digit multiplexing and keypad row strobing.
- Sits between control logic and the display/keypad drivers.

Parameters:
- SEL_W, 3, select width; output width is OUT_W = 2**SEL_W (localparam, not overridable).
- DIV_W, 16, width of the scan-period prescaler.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  output enable; when low, d is blanked and idx and the prescaler hold.
- mode  in  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 OFF.
- s  in  SEL_W  select value: the DIRECT index, or the load value in scan modes.
- load  in  1  one-cycle strobe: idx <= s and prescaler cleared.
- period  in  DIV_W  scan step interval, equal to period+1 clk cycles.
- d  out  OUT_W  registered one-hot output; d[idx] = 1.
- idx  out  SEL_W  registered current index.
- tick  out  1  one-cycle pulse, asserted in the cycle idx advances.

Behaviour:
- Reset (async, on rst high): d = 0, idx = 0, tick = 0, prescaler cnt = 0. Outputs stay at these values while rst is high. Normal operation starts on the first clk edge after rst falls.
- All outputs are registered. No combinational path from inputs to outputs.
- Output rule, evaluated each clock edge:
  - d <= (en && mode != OFF) ? (1 << idx_next) : 0.
  - d is always one-hot or all-zero, never multi-hot.
- DIRECT mode:
  - idx_next = s; d follows s with 1-cycle latency.
  - cnt held at 0; tick = 0.
- SCAN_UP / SCAN_DOWN modes:
  - cnt increments each cycle while en = 1.
  - When cnt == period: cnt <= 0, idx <= idx ± 1 (mod OUT_W), tick = 1 in that same cycle.
  - Otherwise tick = 0.
- Wrap-around: UP goes OUT_W-1 -> 0; DOWN goes 0 -> OUT_W-1. Both wrap with no gap cycle.
- period = 0: idx steps every cycle and tick is held high continuously.
- OFF mode: d = 0, tick = 0, idx and cnt hold.
- en = 0: d = 0, tick = 0, idx and cnt hold. Scanning resumes from the held state when en returns to 1.
- load has priority over a step in the same cycle: idx <= s, cnt <= 0, tick = 0.
  - In DIRECT mode, load is redundant but legal.
  - load with en = 0 still updates idx.
- Mode change mid-scan: idx is kept, cnt is cleared to 0 on any change of mode, and the new direction takes effect on the next step.
- A period change takes effect immediately. If cnt > new period, cnt counts up to its max, wraps to 0, and then matches; no step is lost silently. The bench checks this case.
- Reset asserted mid-scan: immediate return to reset values, independent of clk.

Decomposition:
- Shared package scan_pkg: mode encodings MODE_DIRECT = 2'b00, MODE_SCAN_UP = 2'b01, MODE_SCAN_DOWN = 2'b10, MODE_OFF = 2'b11.
- Sub-module: scan_prescaler (DIV_W counter with sync clear, period compare, tick output).
- Index register and one-hot output register stay in the top module.

Test Plan:
- rst high for 3 cycles, then DIRECT, en = 1, s = 5 → d = 8'b0010_0000 one cycle after s is applied; idx = 5; tick = 0.
- SCAN_UP, period = 3, load with s = 6 → idx sequence 6, 7, 0, 1 with each value held 4 cycles; tick pulses on every step; d one-hot throughout.
- SCAN_DOWN, period = 0, from idx = 1 → idx 1, 0, 7, 6 on consecutive cycles; tick constantly 1.
- SCAN_UP, period = 2; drop en for 5 cycles mid-count, then raise it → d = 0 and tick = 0 while en is low; idx and cnt frozen; counting resumes with the remaining cycles preserved.
- load asserted in the same cycle as a step (cnt == period) with s = 2 → idx = 2, tick = 0, cnt = 0.
- Assert rst asynchronously between clock edges during a scan → d = 0 and idx = 0 before the next edge.
- Repeat the DIRECT sweep over all selects with SEL_W = 4 → 16-bit one-hot output for every value.
